tree_sum_accumulator: RTL and testbench
=======================================

# tree_sum_accumulator

Downstream consumer of the tree adder's 10-bit `sum` output. It accepts one sum per valid/ready handshake and accumulates a window of `WINDOW` samples. It then presents the window total, the window maximum and the sample count on a valid/ready output port, holding them until they are taken. A `flush` input closes a partial window early.

## Interface
- `SUM_W`, 10: width of incoming sum (matches tree adder `sum`)
- `WINDOW`, 4: samples per full window, ≥ 2
- `ACC_W`, 12: total width; must be ≥ `SUM_W + clog2(WINDOW)`
- `CNT_W`, 3: count width; must hold the value `WINDOW`

- `clk`  in  1  rising-edge clock, single clock domain
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  `in_sum` is valid this cycle
- `in_ready`  out  1  block can accept a sample this cycle
- `in_sum`  in  `SUM_W`  unsigned sum from tree adder
- `flush`  in  1  close current partial window (single-cycle pulse)
- `out_valid`  out  1  result registers hold a completed window
- `out_ready`  in  1  downstream takes result
- `out_total`  out  `ACC_W`  unsigned sum of window samples
- `out_max`  out  `SUM_W`  largest sample in window
- `out_count`  out  `CNT_W`  samples in window (1..`WINDOW`)

## Operation
- States: ACCUM, HOLD. `rst` forces ACCUM and clears `acc`, `cnt`, `max_r`, `out_valid`, `out_total`, `out_max` and `out_count` to 0.
- `in_ready` = (state == ACCUM). It is decoded from the state register only, with no combinational path from `out_ready`.
- Accept = `in_valid && in_ready`. On accept:
  - `acc += in_sum`
  - `cnt += 1`
  - `max_r = max(max_r, in_sum)`
- ACCUM → HOLD when either condition holds:
  - (a) accept with `cnt == WINDOW-1`;
  - (b) `flush` with (`cnt > 0` or accept in the same cycle).
- On that transition:
  - `out_total`, `out_max` and `out_count` load the post-update values, so a same-cycle sample is included;
  - `out_valid` ← 1;
  - `acc`, `cnt` and `max_r` clear.
- `flush` with `cnt == 0` and no accept is ignored: no output, state unchanged.
- `flush` in HOLD is ignored.
- HOLD: `in_ready` = 0, so `in_valid` samples are not taken and upstream must hold them. `out_*` stay stable while `out_valid && !out_ready`.
- HOLD → ACCUM on `out_ready`; `out_valid` ← 0. `out_total`, `out_max` and `out_count` keep their last values after that handshake; they are only meaningful while `out_valid` is high.
- Arithmetic is unsigned. With the stated `ACC_W` constraint, overflow cannot occur. For the defaults, the maximum total is 4 × 1023 = 4092.
- Reset mid-window or while in HOLD discards all partial and pending data immediately.

## Timing
- Last sample or flush at edge k → `out_valid` = 1 after edge k, i.e. in cycle k+1.
- Output handshake at edge j → `in_ready` = 1 in cycle j+1. There is no input acceptance in the handshake cycle itself.
- With `in_valid` and `out_ready` held high, a full window costs `WINDOW` + 1 cycles (one HOLD cycle).
- All outputs are registered or state-decoded. No input reaches any output combinationally.

## Test plan
- Full window: accept 62, 50, 1020, 3 on consecutive cycles with `out_ready` = 1 → next cycle `out_valid` = 1, `out_total` = 1135, `out_max` = 1020, `out_count` = 4. `in_ready` is 0 for one cycle, then 1.
- Backpressure: complete a window, then hold `out_ready` = 0 for 3 cycles while driving `in_valid` = 1 with `in_sum` = 7 → `out_valid` and `out_*` are stable, `in_ready` = 0, and 7 is not counted. Releasing `out_ready` lets the next window begin with 7.
- Flush: accept 62, 50, then pulse `flush` → `out_total` = 112, `out_max` = 62, `out_count` = 2.
  - `flush` with `cnt == 0` → `out_valid` stays 0.
  - `flush` coincident with accepting 20 after 62 → total 82, count 2.
- Max values: 4 × 1023 → `out_total` = 4092, `out_max` = 1023, no wrap.
- Reset mid-operation: accept 62, 50, assert `rst` for one cycle, then accept 1, 1, 1, 1 → `out_total` = 4, `out_count` = 4.
- Reset in HOLD → `out_valid` = 0 and all outputs 0 on assertion; `in_ready` = 1 after release.

Source files
------------

// File: rtl/tree_sum_accumulator.sv
// Windowed accumulator behind the tree adder: sums up to WINDOW samples and tracks
// their maximum, then holds total/max/count on a valid/ready port until it is taken.
module tree_sum_accumulator #(
  parameter int SUM_W  = 10,
  parameter int WINDOW = 4,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [SUM_W-1:0] out_max,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SUM_W-1:0] max_r, max_nx;
  logic             accept, close;

  // Ready is pure state decode so out_ready never reaches the upstream handshake.
  assign in_ready = (state == ACCUM);

  always_comb begin
    accept = in_valid && in_ready;
    acc_nx = acc;
    cnt_nx = cnt;
    max_nx = max_r;
    if (accept) begin
      acc_nx = acc + ACC_W'(in_sum);
      cnt_nx = cnt + CNT_W'(1);
      if (in_sum > max_r) max_nx = in_sum;
    end
    // A flush only closes a window that would be non-empty after this cycle.
    close = in_ready && ((accept && cnt == CNT_W'(WINDOW - 1)) ||
                         (flush && (cnt != '0 || accept)));
    state_nx = state;
    case (state)
      ACCUM:   if (close)     state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = ACCUM;
      default:                state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      max_r     <= '0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_max   <= '0;
      out_count <= '0;
    end else begin
      if (close) begin
        // Post-update values, so a sample accepted alongside flush is included.
        out_total <= acc_nx;
        out_max   <= max_nx;
        out_count <= cnt_nx;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        max_r     <= '0;
      end else begin
        acc   <= acc_nx;
        cnt   <= cnt_nx;
        max_r <= max_nx;
        if (state == HOLD && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Scoreboard bench: a window-list model pushes expected results; a negedge monitor
// checks handshake signals every cycle and compares each held result against the queue.
module tb_tree_sum_accumulator;
  localparam int SUM_W = 10, WINDOW = 4, ACC_W = 12, CNT_W = 3;

  logic             clk = 0, rst = 1;
  logic             in_valid = 0, flush = 0, out_ready = 0;
  logic [SUM_W-1:0] in_sum = '0;
  logic             in_ready, out_valid;
  logic [ACC_W-1:0] out_total;
  logic [SUM_W-1:0] out_max;
  logic [CNT_W-1:0] out_count;

  tree_sum_accumulator #(.SUM_W(SUM_W), .WINDOW(WINDOW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
    .out_max(out_max), .out_count(out_count));

  always #5 clk = ~clk;

  typedef struct {int total; int max; int count;} res_t;
  res_t exp_q[$];
  int   win[$];
  bit   hold = 0;
  int   compared = 0, mismatched = 0;

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a list of samples in the open window plus a "result pending" flag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      win.delete(); exp_q.delete(); hold = 0;
    end else if (!hold) begin
      if (in_valid) win.push_back(int'(in_sum));
      if (win.size() == WINDOW || (flush && win.size() > 0)) begin
        res_t r;
        r.total = 0; r.max = 0; r.count = win.size();
        foreach (win[i]) begin
          r.total += win[i];
          if (win[i] > r.max) r.max = win[i];
        end
        exp_q.push_back(r);
        win.delete();
        hold = 1;
      end
    end else if (out_ready) begin
      hold = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", int'(in_ready), int'(!hold));
      chk("out_valid", int'(out_valid), int'(hold));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("out_total", int'(out_total), exp_q[0].total);
          chk("out_max", int'(out_max), exp_q[0].max);
          chk("out_count", int'(out_count), exp_q[0].count);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(bit v, int s, bit f, bit r);
    @(posedge clk); #1;
    in_valid = v; in_sum = SUM_W'(s); flush = f; out_ready = r;
  endtask

  task automatic window4(int a, int b, int c, int d, bit r);
    drive(1, a, 0, r); drive(1, b, 0, r); drive(1, c, 0, r); drive(1, d, 0, r);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_total", int'(out_total), 0);
    chk("rst_out_count", int'(out_count), 0);
    rst = 0;

    // Full window, then backpressure with a waiting 7 that must not be counted.
    window4(62, 50, 1020, 3, 1);
    drive(0, 0, 0, 1);
    window4(100, 200, 300, 400, 0);
    repeat (3) drive(1, 7, 0, 0);
    drive(1, 7, 0, 1);
    window4(7, 8, 9, 10, 1);
    drive(0, 0, 0, 1);

    // Flushes: partial window, empty window, coincident with a sample.
    drive(1, 62, 0, 1); drive(1, 50, 0, 1); drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    repeat (3) drive(0, 0, 1, 1);
    drive(1, 62, 0, 1); drive(1, 20, 1, 1); drive(0, 0, 0, 1);

    // Maximum values.
    window4(1023, 1023, 1023, 1023, 1);
    drive(0, 0, 0, 1);

    // Reset mid-window.
    drive(1, 62, 0, 1); drive(1, 50, 0, 1);
    @(posedge clk); #1; rst = 1; in_valid = 0;
    @(posedge clk); #1; rst = 0;
    window4(1, 1, 1, 1, 1);
    drive(0, 0, 0, 1);

    // Reset while a result is held.
    window4(500, 600, 700, 800, 0);
    drive(0, 0, 0, 0);
    #1;
    chk("hold_before_rst", int'(out_valid), 1);
    rst = 1;
    #1;
    chk("rst_hold_out_valid", int'(out_valid), 0);
    chk("rst_hold_out_total", int'(out_total), 0);
    chk("rst_hold_out_max", int'(out_max), 0);
    chk("rst_hold_out_count", int'(out_count), 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", int'(in_ready), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);

    repeat (6) drive(0, 0, 0, 1);
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
